ser_en_tx: RTL and testbench

SER_EN_TX -- requirements
Module: ser_en_tx

---
 rtl/ser_en_pkg.sv | 24 ++
 rtl/ser_en_bit_timer.sv | 37 +++
 rtl/ser_en_tx.sv | 125 ++++++++++++
 tb/tb_ser_en_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_en_pkg.sv
// Shared types and helpers for the enable-strobed serial transmitter.
// Holds the FSM state enum (with the optional PARITY state) and an even-parity helper.
// Optional feature macro: SER_EN_TX_PARITY_EN adds the PARITY state.
package ser_en_pkg;

`ifdef SER_EN_TX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
`endif

  // Even parity over a zero-extended payload: the XOR of all payload bits.
  function automatic logic even_parity(input logic [31:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/ser_en_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while run_i is high, pulses wrap_o on the last count.
// Latency: wrap_o is combinational from the count; the count restarts at 0 on the following cycle.
// Backpressure: none; the count is held at 0 whenever run_i is low.
// Ports: clk, reset (sync, active-high), run_i (count enable), wrap_o (end of bit period).
module ser_en_bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic wrap_o
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = run_i && (cnt_q == CW'(BIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || wrap_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ser_en_tx.sv
// Serialises a DATA_W-bit word LSB first on d, strobed by en, each bit held BIT_CYCLES cycles.
// Latency: first bit appears the cycle after acceptance; done pulses the cycle after the last bit.
// Backpressure: in_ready is high only in IDLE (and not in reset); inputs are ignored while busy.
// Ports: clk, reset (sync, active-high), in_valid/in_ready/in_data (word handshake),
//        en/d (serial strobe and data), busy (frame in progress), done (end-of-frame pulse).
// Optional feature macro: SER_EN_TX_PARITY_EN appends an even-parity bit to every frame.
module ser_en_tx
  import ser_en_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              en,
  output logic              d,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              done_q, done_d;
  logic              wrap;
  logic              accept;
  logic              last_bit;
`ifdef SER_EN_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  ser_en_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run_i  (busy),
    .wrap_o (wrap)
  );

  assign busy     = (state_q != ST_IDLE);
  assign in_ready = !busy && !reset;
  assign accept   = in_valid && in_ready;
  assign en       = busy;
  assign done     = done_q;
  assign last_bit = (idx_q == IW'(DATA_W - 1));

  // d is forced low outside an active bit so the line idles at 0.
`ifdef SER_EN_TX_PARITY_EN
  assign d = ((state_q == ST_SHIFT) && shreg_q[0]) || ((state_q == ST_PARITY) && par_q);
`else
  assign d = (state_q == ST_SHIFT) && shreg_q[0];
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef SER_EN_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          shreg_d = in_data;
          idx_d   = '0;
`ifdef SER_EN_TX_PARITY_EN
          par_d   = even_parity(32'(in_data));
`endif
        end
      end
      ST_SHIFT: begin
        if (wrap) begin
          if (last_bit) begin
            idx_d = '0;
`ifdef SER_EN_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IW'(1);
            shreg_d = shreg_q >> 1;
          end
        end
      end
`ifdef SER_EN_TX_PARITY_EN
      ST_PARITY: begin
        if (wrap) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef SER_EN_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef SER_EN_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_ser_en_tx.sv
// Self-checking bench for ser_en_tx: two instances (BIT_CYCLES=1 and 3) checked every cycle
// against a frame-timeline model, plus directed frames with hand-computed expectations.
// Respects SER_EN_TX_PARITY_EN for the expected frame length and parity bit.
module tb_ser_en_tx;

`ifdef SER_EN_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 8 + PAR;  // bits per frame

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0]      vld = '0;
  logic [1:0][7:0] dat = '0;
  logic [1:0]      rdy, en, d, busy, done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ser_en_tx #(.DATA_W(8), .BIT_CYCLES(1)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0]),
    .en(en[0]), .d(d[0]), .busy(busy[0]), .done(done[0])
  );

  ser_en_tx #(.DATA_W(8), .BIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1]),
    .en(en[1]), .d(d[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: position within the frame timeline ----------------
  // m_k counts cycles since acceptance: 1..flen carry bits, flen+1 is the done cycle.
  bit        m_act [2];
  int        m_k   [2];
  logic [7:0] m_word [2];
  bit        started = 1'b0;

  function automatic int bc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int flen(input int i);
    return NB * bc(i);
  endfunction

  function automatic logic m_ready(input int i);
    return !reset && (!m_act[i] || m_k[i] == flen(i) + 1);
  endfunction

  function automatic logic m_on(input int i);
    return m_act[i] && m_k[i] <= flen(i);
  endfunction

  function automatic logic m_bit(input int i);
    int idx;
    idx = (m_k[i] - 1) / bc(i);
    if (idx < 8) return m_word[i][idx];
    return ^m_word[i];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i] = 1'b0;
      end else if (vld[i] && m_ready(i)) begin
        m_act[i]  = 1'b1;
        m_k[i]    = 1;
        m_word[i] = dat[i];
      end else if (m_act[i]) begin
        m_k[i] = m_k[i] + 1;
        if (m_k[i] > flen(i) + 1) m_act[i] = 1'b0;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("en[%0d]", i),   32'(en[i]),   32'(m_on(i)));
        chk($sformatf("d[%0d]", i),    32'(d[i]),    32'(m_on(i) ? m_bit(i) : 1'b0));
        chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_on(i)));
        chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_act[i] && m_k[i] == flen(i) + 1));
        chk($sformatf("rdy[%0d]", i),  32'(rdy[i]),  32'(m_ready(i)));
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Presents w on instance i; returns just after the accepting edge (start of bit cycle 1).
  task automatic send(input int i, input logic [7:0] w);
    int n;
    n = 0;
    @(posedge clk); #1;
    dat[i] = w;
    vld[i] = 1'b1;
    @(negedge clk);
    while (!rdy[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("send_timeout", 32'(rdy[i]), 32'd1);
    @(posedge clk); #1;
    vld[i] = 1'b0;
  endtask

  task automatic trace(input int i, input int n,
                       output logic [63:0] ens, output logic [63:0] ds,
                       output logic [63:0] dns, output logic [63:0] rs);
    ens = '0; ds = '0; dns = '0; rs = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ens[c] = en[i];
      ds[c]  = d[i];
      dns[c] = done[i];
      rs[c]  = rdy[i];
    end
  endtask

  logic [63:0] te, td, tn, tr;
  logic [7:0]  rb;
  int          dc;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",  32'(rdy),  32'd0);
    chk("rst_en",   32'(en),   32'd0);
    chk("rst_d",    32'(d),    32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 0xA5, one cycle per bit
    send(0, 8'hA5);
    trace(0, NB + 1, te, td, tn, tr);
    chk("A5_bits",     32'(td[7:0]),         32'hA5);
    chk("A5_en_cnt",   32'($countones(te)),  32'(NB));
    chk("A5_gap",      32'(te[NB]),          32'd0);
    chk("A5_done",     32'(tn[NB]),          32'd1);
    chk("A5_done_cnt", 32'($countones(tn)),  32'd1);

    // 0x01, three cycles per bit
    send(1, 8'h01);
    trace(1, 3 * NB + 1, te, td, tn, tr);
    chk("01_en_cnt", 32'($countones(te)), 32'(3 * NB));
    chk("01_first",  32'(td[2:0]),        32'h7);
    chk("01_d_cnt",  32'($countones(td)), 32'(3 + 3 * PAR));
    chk("01_done",   32'(tn[3 * NB]),     32'd1);
    chk("01_gap",    32'(te[3 * NB]),     32'd0);

    // back-to-back: in_valid held, second word accepted in the done cycle
    @(posedge clk); #1;
    dat[0] = 8'h3C;
    vld[0] = 1'b1;
    @(negedge clk);
    chk("b2b_rdy0", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    dat[0] = 8'hC3;
    trace(0, 2 * NB + 2, te, td, tn, tr);
    vld[0] = 1'b0;
    chk("b2b_bits1",  32'(td[7:0]),           32'h3C);
    chk("b2b_bits2",  32'(td[NB + 8:NB + 1]), 32'hC3);
    chk("b2b_gap",    32'(te[NB]),            32'd0);
    chk("b2b_done1",  32'(tn[NB]),            32'd1);
    chk("b2b_rdy1",   32'(tr[NB]),            32'd1);
    chk("b2b_done2",  32'(tn[2 * NB + 1]),    32'd1);
    chk("b2b_en_cnt", 32'($countones(te)),    32'(2 * NB));

    // reset pulsed during bit 4 of 0xFF
    send(0, 8'hFF);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rmid_rdy_in_reset", 32'(rdy[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_en",   32'(en[0]),   32'd0);
    chk("rmid_rdy",  32'(rdy[0]),  32'd1);
    dc = int'(done[0]);
    repeat (NB) begin
      @(negedge clk);
      dc += int'(done[0]);
    end
    chk("rmid_no_done", 32'(dc), 32'd0);
    send(0, 8'h0F);
    trace(0, NB + 1, te, td, tn, tr);
    chk("0F_bits", 32'(td[7:0]), 32'h0F);
    chk("0F_done", 32'(tn[NB]),  32'd1);

    // in_data / in_valid churn while busy must not disturb the frame
    send(1, 8'h5A);
    te = '0; td = '0; tr = '0;
    for (int c = 0; c <= 3 * NB; c++) begin
      @(negedge clk);
      te[c] = en[1];
      td[c] = d[1];
      tr[c] = rdy[1];
      if (c == 1) begin
        dat[1] = 8'hFF;
        vld[1] = 1'b1;
      end
      if (c == 3 * NB - 2) vld[1] = 1'b0;
    end
    for (int j = 0; j < 8; j++) rb[j] = td[3 * j];
    chk("mid_bits",    32'(rb),               32'h5A);
    chk("mid_rdy_cnt", 32'($countones(tr)),   32'd1);
    chk("mid_rdy_end", 32'(tr[3 * NB]),       32'd1);

`ifdef SER_EN_TX_PARITY_EN
    send(0, 8'h07);
    trace(0, NB + 1, te, td, tn, tr);
    chk("par07_bit",  32'(td[8]), 32'd1);
    chk("par07_en",   32'(te[8]), 32'd1);
    chk("par07_done", 32'(tn[9]), 32'd1);
    send(0, 8'h03);
    trace(0, NB + 1, te, td, tn, tr);
    chk("par03_bit",  32'(td[8]), 32'd0);
    chk("par03_en",   32'(te[8]), 32'd1);
`endif

    // randomized traffic, data churn and occasional resets on both instances
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 2) != 0);
        dat[i] = 8'($urandom);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    vld = '0;
    repeat (60) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

endmodule
